// File: rtl/sram_read_datapath.sv
// Read datapath behind the SRAM sequencer: address counter, capture register and a
// first-word-fall-through output FIFO with back-pressure. Optional macro: ADDR_LIMIT_EN.
module sram_read_datapath #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_LAST = 2047
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       increment,
    input  logic                       latch,
    input  logic                       dataValid,
    input  logic                       addr_load,
    input  logic [ADDR_W-1:0]          addr_start,
    input  logic [DATA_W-1:0]          sram_data_in,
    output logic [ADDR_W-1:0]          sram_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       stall,
    output logic                       wrap,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

`ifdef ADDR_LIMIT_EN
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(ADDR_LAST);
`else
    // Full binary range; OR-ing with all-ones makes ADDR_LAST irrelevant here.
    localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}} | ADDR_W'(ADDR_LAST);
`endif

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              full;
    logic              push_req;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic              incr_ok;
    logic [ADDR_W-1:0] load_val;

    assign full     = (cnt_q == FULL_CNT);
    assign push_req = dataValid & hold_full_q;
    assign pop      = (cnt_q != '0) & rd_ready;
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;
    // Hold the address still whenever the word for it is being thrown away.
    assign incr_ok  = increment & ~(stall & drop);

`ifdef ADDR_LIMIT_EN
    assign load_val = (addr_start > ADDR_TOP) ? '0 : addr_start;
`else
    assign load_val = addr_start;
`endif

    always_comb begin
        addr_d = addr_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q | drop;
        if (addr_load) begin
            addr_d = load_val;
            ovf_d  = 1'b0;
        end else if (incr_ok) begin
            if (addr_q == ADDR_TOP) begin
                addr_d = '0;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (latch) begin
            hold_d      = sram_data_in;
            hold_full_d = 1'b1;
        end else if (push_req) begin
            hold_full_d = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            wrap_q      <= 1'b0;
            ovf_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            wrap_q      <= wrap_d;
            ovf_q       <= ovf_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= hold_q;
        end
    end

    assign sram_addr  = addr_q;
    assign rd_data    = mem_q[rd_ptr_q];
    assign rd_valid   = (cnt_q != '0);
    assign fifo_count = cnt_q;
    assign stall      = (cnt_q >= STALL_CNT);
    assign wrap       = wrap_q;
    assign overflow   = ovf_q;

endmodule
